// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx
// Parallel-to-serial transmit stage. Bytes come in over a valid/ready handshake,
// are buffered, and leave MSB-first on data_out at one bit per clk_32f cycle.
// After reset the line carries SYNC_COMMAS comma bytes so the receiver can lock,
// then buffered data, or BC_SYMBOL as idle filler.
// Build option: define TX_FIFO_EN for a FIFO_DEPTH-entry circular FIFO buffer
// (FIFO_DEPTH must be a power of 2, at least 2); without it the buffer is a single
// holding register.
module paralelo_serial_tx #(
    parameter logic [7:0] BC_SYMBOL   = 8'hBC,
    parameter int         SYNC_COMMAS = 4,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out,
    output logic       byte_strobe
);

    typedef enum logic {
        SYNC,
        ACTIVE
    } state_e;

    state_e     state_q;
    logic [2:0] bitCnt_q;
    logic [7:0] shreg_q;
    logic [3:0] commaCnt_q;
    logic       strobe_q;
    logic       active_q;
    logic       reset_q;

    logic       full;
    logic       empty;
    logic [7:0] head;
    logic       boundary;
    logic       loadData;
    logic       push;
    logic       pop;
    logic       bypass;
    logic       write;
    logic [7:0] byte_d;

    // The byte boundary is the last bit of a byte; loads happen at its closing edge.
    // Data may be loaded once the final sync comma has been sent, or any time in ACTIVE.
    // An accept arriving on a boundary with an empty buffer goes straight to the
    // shift register, which gives the one-cycle best-case latency.
    assign boundary  = (bitCnt_q == 3'd7);
    assign loadData  = boundary && ((state_q == ACTIVE) || (commaCnt_q == 4'(SYNC_COMMAS)));
    assign push      = valid_in && ready_out;
    assign pop       = loadData && !empty;
    assign bypass    = loadData && empty && push;
    assign write     = push && !bypass;
    assign ready_out = !reset_q && !full;

    assign data_out    = shreg_q[7];
    assign byte_strobe = strobe_q;
    assign active_out  = active_q;

`ifdef TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wrPtr_q;
    logic [AW:0] rdPtr_q;
    logic [7:0]  mem_q [FIFO_DEPTH];

    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign head  = mem_q[rdPtr_q[AW-1:0]];

    // Pointer bookkeeping; reset empties the FIFO and discards anything queued.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (write) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_32f) begin
        if (write) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_in;
        end
    end
`else
    localparam int UNUSED_FIFO_DEPTH = FIFO_DEPTH;

    logic [7:0] hold_q;
    logic       holdValid_q;

    assign empty = !holdValid_q;
    assign full  = holdValid_q;
    assign head  = hold_q;

    // Single holding register. A write needs an empty slot and a pop needs a full
    // one, so the two never coincide; the freed slot opens ready_out a cycle later.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            hold_q      <= '0;
            holdValid_q <= 1'b0;
        end else if (write) begin
            hold_q      <= data_in;
            holdValid_q <= 1'b1;
        end else if (pop) begin
            holdValid_q <= 1'b0;
        end
    end
`endif

    // Pick the byte loaded at the next boundary: buffered head, bypassed input, or comma/idle.
    always_comb begin
        byte_d = BC_SYMBOL;
        if (pop) begin
            byte_d = head;
        end else if (bypass) begin
            byte_d = data_in;
        end
    end

    // Sync/active sequencer plus bit counter and shift register. The first cycle out
    // of reset preloads a comma (counted as comma 1) so bytes align to reset release.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            reset_q    <= 1'b1;
            state_q    <= SYNC;
            bitCnt_q   <= 3'd0;
            shreg_q    <= 8'h00;
            commaCnt_q <= 4'd0;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
        end else if (reset_q) begin
            reset_q    <= 1'b0;
            bitCnt_q   <= 3'd0;
            shreg_q    <= BC_SYMBOL;
            commaCnt_q <= 4'd1;
            strobe_q   <= 1'b1;
        end else begin
            bitCnt_q <= bitCnt_q + 3'd1;
            strobe_q <= boundary;
            if (boundary) begin
                shreg_q <= byte_d;
                if (loadData) begin
                    state_q  <= ACTIVE;
                    active_q <= 1'b1;
                end else begin
                    commaCnt_q <= commaCnt_q + 4'd1;
                end
            end else begin
                shreg_q <= {shreg_q[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx
// Bench for paralelo_serial_tx: an abstract model tracks time since reset release
// and a byte queue, and the line is compared against it every cycle. Directed
// scenarios add literal expectations on top of the model.
module tb_paralelo_serial_tx;

    localparam logic [7:0] BC   = 8'hBC;
    localparam int         SYNC = 4;
`ifdef TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk_32f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       active_out;
    logic       byte_strobe;

    int total = 0;
    int bad = 0;

    paralelo_serial_tx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .active_out  (active_out),
        .byte_strobe (byte_strobe)
    );

    // Free-running bit clock.
    always #5 clk_32f = ~clk_32f;

    // Compare one value and log a failure line when it differs.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: t counts cycles since reset release; every 8th cycle a new byte starts.
    // The first SYNC bytes are commas, later ones take the oldest queued byte or idle.
    bit         mStarted = 1'b0;
    bit         mRq = 1'b1;
    int         t = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] mq[$];

    // Advance the model on each active edge using the inputs presented for that edge.
    always @(posedge clk_32f) begin
        bit acc;
        acc = mStarted && !mRq && (mq.size() < CAP) && valid_in;
        if (reset) begin
            mStarted = 1'b1;
            mRq = 1'b1;
            mq.delete();
            t = 0;
            cur = 8'h00;
        end else if (mStarted) begin
            if (acc) mq.push_back(data_in);
            if (mRq) begin
                mRq = 1'b0;
                t = 0;
                cur = BC;
            end else begin
                t++;
                if (t % 8 == 0) begin
                    if (t >= 8 * SYNC && mq.size() > 0) cur = mq.pop_front();
                    else cur = BC;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk_32f) begin
        if (mStarted) begin
            if (mRq) begin
                checkOutput("cyc rst data_out", data_out, 0);
                checkOutput("cyc rst ready_out", ready_out, 0);
                checkOutput("cyc rst active_out", active_out, 0);
                checkOutput("cyc rst byte_strobe", byte_strobe, 0);
            end else begin
                checkOutput("cyc data_out", data_out, cur[7 - (t % 8)]);
                checkOutput("cyc byte_strobe", byte_strobe, (t % 8 == 0));
                checkOutput("cyc active_out", active_out, (t >= 8 * SYNC));
                checkOutput("cyc ready_out", ready_out, (mq.size() < CAP));
            end
        end
    end

    // Reassemble bytes from the DUT line, framed by byte_strobe.
    logic [7:0] capBytes[$];
    logic [7:0] capSh = 8'h00;
    int         capN = 0;
    always @(negedge clk_32f) begin
        if (mRq) begin
            capBytes.delete();
            capN = 0;
        end else begin
            if (byte_strobe) begin
                capSh = {7'b0, data_out};
                capN = 1;
            end else if (capN > 0) begin
                capSh = {capSh[6:0], data_out};
                capN++;
            end
            if (capN == 8) begin
                capBytes.push_back(capSh);
                capN = 0;
            end
        end
    end

    // Step to just after the next falling edge.
    task automatic tick();
        @(negedge clk_32f);
        #1;
    endtask

    // Offer one byte and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [7:0] b, input string name);
        int waited;
        waited = 0;
        valid_in = 1'b1;
        data_in = b;
        while (ready_out !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        checkOutput({name, " accept"}, (waited < 200), 1);
        tick();
        valid_in = 1'b0;
    endtask

    // Pulse reset for two cycles and step past the release edge.
    task automatic applyReset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // Wait (bounded) until n bytes have been reassembled from the line.
    task automatic waitBytes(input int n, input string name);
        int w;
        w = 0;
        while (capBytes.size() < n && w < 2000) begin
            tick();
            w++;
        end
        checkOutput(name, (capBytes.size() >= n), 1);
    endtask

    // Directed scenarios.
    initial begin
        logic [31:0] bits;
        int base, idx, nAcc, nData, w;
        logic acc;
        logic [7:0] got[$];

        // T1: reset state, release, 32 comma bits, then active idle
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("T1 reset data_out", data_out, 0);
        checkOutput("T1 reset ready_out", ready_out, 0);
        checkOutput("T1 reset active_out", active_out, 0);
        checkOutput("T1 reset byte_strobe", byte_strobe, 0);
        reset = 1'b0;
        checkOutput("T1 ready before release edge", ready_out, 0);
        tick();
        bits = 32'h0;
        for (int i = 0; i < 32; i++) begin
            bits = {bits[30:0], data_out};
            if (i % 8 == 0) checkOutput("T1 comma strobe", byte_strobe, 1);
            if (i == 31) checkOutput("T1 active before sync end", active_out, 0);
            tick();
        end
        checkOutput("T1 comma bits", bits, 32'hBCBCBCBC);
        checkOutput("T1 active after sync", active_out, 1);
        checkOutput("T1 strobe first post-sync", byte_strobe, 1);
        repeat (16) tick();

        // T2: byte pushed during SYNC becomes the 5th byte
        applyReset();
        repeat (3) tick();
        applyStimulus(8'hA5, "T2");
        waitBytes(6, "T2 drain");
        checkOutput("T2 byte1", capBytes[0], BC);
        checkOutput("T2 byte4", capBytes[3], BC);
        checkOutput("T2 byte5", capBytes[4], 8'hA5);
        checkOutput("T2 byte6 idle", capBytes[5], BC);

        // T3: four back-to-back pushes go out in order with no idle between them
        base = capBytes.size();
        applyStimulus(8'h01, "T3 b1");
        applyStimulus(8'h02, "T3 b2");
        applyStimulus(8'h03, "T3 b3");
        applyStimulus(8'h04, "T3 b4");
        waitBytes(base + 8, "T3 drain");
        idx = -1;
        for (int i = base; i < capBytes.size(); i++)
            if (idx < 0 && capBytes[i] == 8'h01) idx = i;
        checkOutput("T3 found 01", (idx >= 0), 1);
        if (idx < 0) idx = base;
        for (int k = 1; k < 4; k++)
            checkOutput($sformatf("T3 byte after 01 +%0d", k), capBytes[idx + k], k + 1);

        // T4: valid held high for 64 cycles with incrementing data
        base = capBytes.size();
        nAcc = 0;
        valid_in = 1'b1;
        data_in = 8'h10;
        for (int c = 0; c < 64; c++) begin
            acc = ready_out;
            tick();
            if (acc) begin
                nAcc++;
                data_in = data_in + 8'h01;
            end
        end
        valid_in = 1'b0;
        checkOutput("T4 accept count in 8..9", (nAcc >= 8 && nAcc <= 9), 1);
        waitBytes(base + nAcc + 4, "T4 drain");
        got.delete();
        for (int i = base; i < capBytes.size(); i++)
            if (capBytes[i] != BC) got.push_back(capBytes[i]);
        checkOutput("T4 data byte count", got.size(), nAcc);
        for (int k = 0; k < got.size(); k++)
            checkOutput($sformatf("T4 data %0d", k), got[k], 8'h10 + k);

        // T5: reset mid-byte aborts data and discards queued bytes
        applyStimulus(8'hF0, "T5 F0");
        applyStimulus(8'h11, "T5 11");
        w = 0;
        while (!(cur == 8'hF0 && t % 8 == 3) && w < 100) begin
            tick();
            w++;
        end
        checkOutput("T5 reached bit 3 of F0", (w < 100), 1);
        reset = 1'b1;
        tick();
        checkOutput("T5 data_out after reset", data_out, 0);
        checkOutput("T5 ready_out after reset", ready_out, 0);
        checkOutput("T5 active_out after reset", active_out, 0);
        reset = 1'b0;
        tick();
        waitBytes(10, "T5 drain");
        nData = 0;
        for (int i = 0; i < capBytes.size(); i++)
            if (capBytes[i] != BC) nData++;
        checkOutput("T5 no stale bytes", nData, 0);

        // T6: second push stalls behind the first, then both go out in order
        w = 0;
        while (!(active_out === 1'b1 && t % 8 == 2) && w < 100) begin
            tick();
            w++;
        end
        checkOutput("T6 reached active phase 2", (w < 100), 1);
        base = capBytes.size();
        applyStimulus(8'h3C, "T6 3C");
`ifndef TX_FIFO_EN
        checkOutput("T6 stall ready_out", ready_out, 0);
`endif
        applyStimulus(8'hC3, "T6 C3");
        waitBytes(base + 5, "T6 drain");
        idx = -1;
        for (int i = base; i < capBytes.size(); i++)
            if (idx < 0 && capBytes[i] == 8'h3C) idx = i;
        checkOutput("T6 found 3C", (idx >= 0), 1);
        if (idx < 0) idx = base;
        checkOutput("T6 C3 follows 3C", capBytes[idx + 1], 8'hC3);

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
